pc_sequencer: RTL

Fetch/step controller that drives the command side of the pc_function program counter: it reads instruction bytes from program memory at the current PC, decodes them, and issues increment, decrement or load commands through M/DATA_OUTPUT with a single gated step strobe (PC_CLK). It sits between program ROM and pc_function in the CPU datapath. The counter advances only on PC_CLK, so the sequencer fully controls when the PC moves.

---
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/step controller for the pc_function program counter.
// Reads opcodes (and jump operands) from program memory at PC_IN and issues one
// gated PC_CLK low pulse per step, with M/DATA_OUTPUT set up a cycle in advance.
module pc_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       START,
  input  logic [7:0] PC_IN,
  input  logic       FLAG_Z,
  input  logic [7:0] MEM_DATA,
  input  logic       MEM_READY,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RD,
  output logic [1:0] M,
  output logic [7:0] DATA_OUTPUT,
  output logic       PC_CLK,
  output logic [7:0] INSTR,
  output logic       BUSY,
  output logic       HALTED,
  output logic       ERR
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] M_INC  = 2'b00;
  localparam logic [1:0] M_DEC  = 2'b01;
  localparam logic [1:0] M_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SETUP,
    S_STEP,
    S_SETTLE,
    S_OPFETCH,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [1:0]          m_q, m_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                pc_clk_q, pc_clk_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic                phase_q, phase_d;
  logic                taken_q, taken_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // State and registered outputs; clr forces PC_CLK high asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      m_q        <= M_INC;
      dout_q     <= '0;
      pc_clk_q   <= 1'b1;
      instr_q    <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      phase_q    <= 1'b0;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      m_q        <= m_d;
      dout_q     <= dout_d;
      pc_clk_q   <= pc_clk_d;
      instr_q    <= instr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      phase_q    <= phase_d;
      taken_q    <= taken_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    m_d        = m_q;
    dout_d     = dout_q;
    pc_clk_d   = 1'b1;
    instr_d    = instr_q;
    err_d      = err_q;
    phase_d    = phase_q;
    taken_d    = taken_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = PC_IN;
          cnt_d      = '0;
        end
      end
      S_FETCH, S_OPFETCH: begin
        mem_addr_d = PC_IN;
        if (MEM_READY) begin
          mem_rd_d = 1'b0;
          if (state_q == S_FETCH) begin
            instr_d = MEM_DATA;
            state_d = S_DECODE;
          end else begin
            dout_d  = MEM_DATA;
            m_d     = taken_q ? M_LOAD : M_INC;
            phase_d = 1'b0;
            state_d = S_SETUP;
          end
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_SETUP;
        case (instr_q[7:6])
          2'b00: m_d = M_INC;
          2'b01: begin
            // First step skips the opcode; the operand decides the second.
            m_d     = M_INC;
            phase_d = 1'b1;
            taken_d = !instr_q[5] || FLAG_Z;
          end
          2'b10: m_d = M_DEC;
          2'b11: state_d = S_HALT;
        endcase
      end
      S_SETUP: begin
        pc_clk_d = 1'b0;
        state_d  = S_STEP;
      end
      S_STEP: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d    = phase_q ? S_OPFETCH : S_FETCH;
        mem_rd_d   = 1'b1;
        mem_addr_d = PC_IN;
        cnt_d      = '0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  assign MEM_ADDR    = mem_addr_q;
  assign MEM_RD      = mem_rd_q;
  assign M           = m_q;
  assign DATA_OUTPUT = dout_q;
  assign PC_CLK      = pc_clk_q;
  assign INSTR       = instr_q;
  assign BUSY        = busy_q;
  assign HALTED      = halted_q;
  assign ERR         = err_q;

endmodule
